// File: rtl/phase_frame_parser_pkg.sv
// Shared protocol constants and types for the phase command parser.
// Frame: SOF, CMD, payload, CSUM where CSUM = XOR of CMD and payload.
package phase_proto_pkg;

  localparam logic [7:0] SOF_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_ONE = 8'h01;
  localparam logic [7:0] CMD_SET_ALL = 8'h02;

  typedef logic [7:0] phase_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } parser_state_t;

endpackage

// File: rtl/phase_frame_parser_if.sv
// Byte stream from the receive FIFO into the parser.
// A byte transfers on a rising clock edge where rx_valid && rx_ready; rx_data is stable while rx_valid.
interface phase_frame_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/phase_frame_parser_timeout.sv
// Saturating inter-byte idle counter; expired_o holds once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module frame_timeout #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/phase_frame_parser.sv
// Parses framed host phase commands and maintains the committed per-channel phase bank.
// SET_ALL bytes land in a shadow bank and are copied in one cycle on a good checksum.
module phase_frame_parser
  import phase_proto_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 sys_clk,
  input  logic                 ext_rst,
  phase_frame_parser_if.slave  rx,
  input  logic                 err_clr,
  output phase_t               phases_out [0:NUM_CHANNELS-1],
  output logic                 phase_update,
  output logic                 read_error,
  output parser_state_t        state_o
);

  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);

  parser_state_t state_q, state_d;
  logic [7:0]    xor_q, xor_d;
  logic          is_all_q, is_all_d;
  logic          bad_idx_q, bad_idx_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] cnt_q, cnt_d;
  phase_t        stage_q, stage_d;
  phase_t        shadow_q [0:NUM_CHANNELS-1];
  phase_t        shadow_d [0:NUM_CHANNELS-1];
  phase_t        phases_q [0:NUM_CHANNELS-1];
  phase_t        phases_d [0:NUM_CHANNELS-1];
  logic          upd_q, upd_d;
  logic          err_q, err_d;
  logic          rdy_q;
  logic          acc;
  logic          err_set;
  logic          expired;
  logic [7:0]    b;

  assign acc = rx.rx_valid && rdy_q;
  assign b   = rx.rx_data;

  frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (sys_clk),
    .rst       (ext_rst),
    .restart_i (acc),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    xor_d     = xor_q;
    is_all_d  = is_all_q;
    bad_idx_d = bad_idx_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    shadow_d  = shadow_q;
    phases_d  = phases_q;
    upd_d     = 1'b0;
    err_set   = 1'b0;
    if (acc) begin
      case (state_q)
        ST_IDLE: begin
          if (b == SOF_BYTE) begin
            state_d = ST_CMD;
            xor_d   = 8'h00;
          end
        end
        ST_CMD: begin
          xor_d     = xor_q ^ b;
          bad_idx_d = 1'b0;
          if (b == CMD_SET_ONE) begin
            state_d  = ST_ADDR;
            is_all_d = 1'b0;
          end else if (b == CMD_SET_ALL) begin
            state_d  = ST_DATA;
            is_all_d = 1'b1;
            cnt_d    = '0;
          end else begin
            err_set = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_ADDR: begin
          // Range check on the full byte; the frame is still consumed when bad.
          xor_d     = xor_q ^ b;
          bad_idx_d = (32'(b) >= NUM_CHANNELS);
          idx_d     = b[IW-1:0];
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          xor_d = xor_q ^ b;
          if (!is_all_q) begin
            stage_d = b;
            state_d = ST_CSUM;
          end else begin
            shadow_d[cnt_q] = b;
            if (cnt_q == LAST_IDX) begin
              state_d = ST_CSUM;
            end else begin
              cnt_d = cnt_q + IW'(1);
            end
          end
        end
        ST_CSUM: begin
          if ((b == xor_q) && !bad_idx_q) begin
            upd_d = 1'b1;
            if (is_all_q) begin
              phases_d = shadow_q;
            end else begin
              phases_d[idx_q] = stage_q;
            end
          end else begin
            err_set = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expired && (state_q != ST_IDLE)) begin
      err_set = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge ext_rst) begin
    if (ext_rst) begin
      state_q   <= ST_IDLE;
      xor_q     <= 8'h00;
      is_all_q  <= 1'b0;
      bad_idx_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      stage_q   <= 8'h00;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= 8'h00;
        phases_q[i] <= 8'h00;
      end
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      xor_q     <= xor_d;
      is_all_q  <= is_all_d;
      bad_idx_q <= bad_idx_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      shadow_q  <= shadow_d;
      phases_q  <= phases_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end

  assign rx.rx_ready   = rdy_q;
  assign phases_out    = phases_q;
  assign phase_update  = upd_q;
  assign read_error    = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_phase_frame_parser.sv
// Bench for phase_frame_parser: directed protocol frames plus random frames scored against a frame-level model.
module tb_phase_frame_parser;
  import phase_proto_pkg::*;

  localparam int N  = 4;
  localparam int TO = 50000;

  typedef logic [7:0] byte_q_t [$];

  logic          sys_clk = 1'b0;
  logic          ext_rst;
  logic          err_clr;
  phase_t        phases_out [0:N-1];
  logic          phase_update;
  logic          read_error;
  parser_state_t state_o;

  phase_frame_parser_if rx_if();

  phase_frame_parser #(.NUM_CHANNELS(N), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk      (sys_clk),
    .ext_rst      (ext_rst),
    .rx           (rx_if.slave),
    .err_clr      (err_clr),
    .phases_out   (phases_out),
    .phase_update (phase_update),
    .read_error   (read_error),
    .state_o      (state_o)
  );

  always #10 sys_clk = ~sys_clk;

  int         checks = 0;
  int         passed = 0;
  int         upd_cnt = 0;
  logic [7:0] exp_ph [0:N-1];
  logic       exp_err;

  always @(negedge sys_clk) if (phase_update === 1'b1) upd_cnt++;

  // Driver: holds the byte for one edge; back-to-back calls give gapless transfers.
  task automatic send_byte(input logic [7:0] v);
    rx_if.rx_data  = v;
    rx_if.rx_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge sys_clk);
    #1;
    err_clr = 1'b0;
  endtask

  // Frame-level reference: walk whole frames and apply the command semantics.
  task automatic model_frame(input byte_q_t q, output int commits);
    int i;
    logic [7:0] cmd, x;
    commits = 0;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != 8'hA5) begin
        i++;
      end else begin
        cmd = q[i+1];
        if (cmd == 8'h01) begin
          x = cmd ^ q[i+2] ^ q[i+3];
          if ((q[i+4] == x) && (int'(q[i+2]) < N)) begin
            exp_ph[q[i+2]] = q[i+3];
            commits++;
          end else exp_err = 1'b1;
          i += 5;
        end else if (cmd == 8'h02) begin
          x = cmd;
          for (int k = 0; k < N; k++) x ^= q[i+2+k];
          if (q[i+2+N] == x) begin
            for (int k = 0; k < N; k++) exp_ph[k] = q[i+2+k];
            commits++;
          end else exp_err = 1'b1;
          i += 3 + N;
        end else begin
          exp_err = 1'b1;
          i += 2;
        end
      end
    end
  endtask

  // Sends a frame, checks the commit cycle, then the cycle after it.
  task automatic run_frame(input string name, input byte_q_t q);
    int commits, u0;
    u0 = upd_cnt;
    model_frame(q, commits);
    send_frame(q);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (phases_out[k] !== exp_ph[k])
        $display("FAIL %s phases_out[%0d]: got %h expected %h", name, k, phases_out[k], exp_ph[k]);
      else passed++;
    end
    checks++;
    if (phase_update !== (commits > 0))
      $display("FAIL %s phase_update: got %b expected %b", name, phase_update, commits > 0);
    else passed++;
    checks++;
    if (read_error !== exp_err)
      $display("FAIL %s read_error: got %b expected %b", name, read_error, exp_err);
    else passed++;
    @(posedge sys_clk);
    #1;
    checks++;
    if ((upd_cnt - u0) !== commits)
      $display("FAIL %s update_pulses: got %0d expected %0d", name, upd_cnt - u0, commits);
    else passed++;
    checks++;
    if (phase_update !== 1'b0)
      $display("FAIL %s phase_update_drop: got %b expected 0", name, phase_update);
    else passed++;
  endtask

  task automatic test_reset();
    ext_rst = 1'b1;
    err_clr = 1'b0;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (rx_if.rx_ready !== 1'b0) $display("FAIL reset rx_ready: got %b expected 0", rx_if.rx_ready);
    else passed++;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (phases_out[k] !== 8'h00) $display("FAIL reset phases_out[%0d]: got %h expected 00", k, phases_out[k]);
      else passed++;
    end
    checks++;
    if ({phase_update, read_error} !== 2'b00)
      $display("FAIL reset flags: got %b expected 00", {phase_update, read_error});
    else passed++;
    ext_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    checks++;
    if (rx_if.rx_ready !== 1'b1) $display("FAIL release rx_ready: got %b expected 1", rx_if.rx_ready);
    else passed++;
    checks++;
    if (state_o !== ST_IDLE) $display("FAIL release state: got %0d expected %0d", state_o, ST_IDLE);
    else passed++;
    for (int k = 0; k < N; k++) exp_ph[k] = 8'h00;
    exp_err = 1'b0;
  endtask

  task automatic test_set_one();
    run_frame("set_one", '{8'hA5, 8'h01, 8'h02, 8'h3C, 8'h3F});
  endtask

  task automatic test_set_all();
    send_frame('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h40});
    checks++;
    if (phases_out[3] !== exp_ph[3] || phases_out[0] !== exp_ph[0])
      $display("FAIL set_all_partial: got %h/%h expected %h/%h", phases_out[0], phases_out[3], exp_ph[0], exp_ph[3]);
    else passed++;
    for (int k = 0; k < N; k++) exp_ph[k] = 8'h10 * (k + 1);
    send_byte(8'h42);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (phases_out[k] !== exp_ph[k])
        $display("FAIL set_all phases_out[%0d]: got %h expected %h", k, phases_out[k], exp_ph[k]);
      else passed++;
    end
    checks++;
    if (phase_update !== 1'b1) $display("FAIL set_all phase_update: got %b expected 1", phase_update);
    else passed++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_bad_csum();
    run_frame("bad_csum", '{8'hA5, 8'h01, 8'h02, 8'h3C, 8'h00});
    repeat (5) @(posedge sys_clk);
    #1;
    checks++;
    if (read_error !== 1'b1) $display("FAIL error_sticky: got %b expected 1", read_error);
    else passed++;
    pulse_clr();
    exp_err = 1'b0;
    checks++;
    if (read_error !== 1'b0) $display("FAIL error_clear: got %b expected 0", read_error);
    else passed++;
    // Clear coinciding with a new error: the error survives.
    send_frame('{8'hA5, 8'h01, 8'h02, 8'h3C});
    err_clr = 1'b1;
    send_byte(8'h01);
    err_clr = 1'b0;
    checks++;
    if (read_error !== 1'b1) $display("FAIL set_wins: got %b expected 1", read_error);
    else passed++;
    pulse_clr();
  endtask

  task automatic test_bad_index();
    run_frame("bad_index", '{8'hA5, 8'h01, 8'h07, 8'h11, 8'h17});
    pulse_clr();
    exp_err = 1'b0;
    run_frame("bad_cmd", '{8'hA5, 8'h03, 8'h01});
    pulse_clr();
    exp_err = 1'b0;
  endtask

  task automatic test_timeout();
    send_frame('{8'hA5, 8'h02, 8'h10, 8'h20});
    repeat (TO - 10) @(posedge sys_clk);
    #1;
    checks++;
    if (read_error !== 1'b0 || state_o !== ST_DATA)
      $display("FAIL timeout_early: got err=%b state=%0d expected err=0 state=%0d", read_error, state_o, ST_DATA);
    else passed++;
    repeat (20) @(posedge sys_clk);
    #1;
    checks++;
    if (read_error !== 1'b1 || state_o !== ST_IDLE)
      $display("FAIL timeout: got err=%b state=%0d expected err=1 state=%0d", read_error, state_o, ST_IDLE);
    else passed++;
    pulse_clr();
    run_frame("after_timeout", '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h54});
  endtask

  task automatic test_junk_and_sof_data();
    run_frame("junk", '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h01, 8'h77, 8'h77});
    run_frame("sof_as_data", '{8'hA5, 8'h01, 8'h03, 8'hA5, 8'hA7});
  endtask

  task automatic test_back_to_back();
    run_frame("back_to_back", '{8'hA5, 8'h01, 8'h00, 8'h9A, 8'h9B, 8'hA5, 8'h01, 8'h02, 8'h5E, 8'h5D});
  endtask

  task automatic test_reset_mid_frame();
    send_frame('{8'hA5, 8'h02, 8'h11, 8'h22});
    #4 ext_rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (phases_out[k] !== 8'h00) $display("FAIL async_reset phases_out[%0d]: got %h expected 00", k, phases_out[k]);
      else passed++;
    end
    @(posedge sys_clk);
    #1 ext_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < N; k++) exp_ph[k] = 8'h00;
    exp_err = 1'b0;
    run_frame("post_reset_tail", '{8'h33, 8'h44, 8'h46});
  endtask

  task automatic test_random();
    byte_q_t q;
    logic [7:0] x, v;
    int kind;
    for (int f = 0; f < 40; f++) begin
      q = {};
      repeat ($urandom_range(0, 2)) begin
        v = 8'($urandom_range(0, 255));
        q.push_back((v == 8'hA5) ? 8'h00 : v);
      end
      q.push_back(8'hA5);
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        q.push_back(8'h01);
        q.push_back(8'($urandom_range(0, 5)));
        q.push_back(8'($urandom_range(0, 255)));
        x = 8'h01 ^ q[q.size()-2] ^ q[q.size()-1];
      end else if (kind < 9) begin
        q.push_back(8'h02);
        x = 8'h02;
        for (int k = 0; k < N; k++) begin
          v = 8'($urandom_range(0, 255));
          q.push_back(v);
          x ^= v;
        end
      end else begin
        q.push_back(8'($urandom_range(3, 255)));
      end
      if (kind < 9) q.push_back(($urandom_range(0, 4) == 0) ? ~x : x);
      run_frame("random", q);
      if (exp_err) begin
        pulse_clr();
        exp_err = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_one();
    test_set_all();
    test_bad_csum();
    test_bad_index();
    test_junk_and_sof_data();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_timeout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
